// File: rtl/rgmii_tx_rate_adapter.sv
// GMII-to-RGMII transmit rate adapter: presents each GMII byte as ODDR edge data,
// stretching byte slots to 2*DIV cycles and generating a divided TXC in 10/100M modes.
module rgmii_tx_rate_adapter #(
   parameter int DIV_100 = 5,
   parameter int DIV_10  = 50
) (
   input  logic       gmii_tx_clk,
   input  logic       reset,
   input  logic [1:0] speed_selection,
   input  logic [7:0] s_txd,
   input  logic       s_tx_en,
   input  logic       s_tx_er,
   output logic       s_tx_ready,
   output logic       txc_d1,
   output logic       txc_d2,
   output logic [3:0] td_d1,
   output logic [3:0] td_d2,
   output logic       ctl_d1,
   output logic       ctl_d2,
   output logic [1:0] speed_active,
   output logic       speed_change
);

   localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
   localparam int CW      = $clog2(DIV_MAX);
   localparam logic [CW-1:0] LAST_100 = CW'(DIV_100 - 1);
   localparam logic [CW-1:0] LAST_10  = CW'(DIV_10 - 1);

   typedef enum logic {PH_LO, PH_HI} phase_t;

   logic [CW-1:0] cnt_q, cnt_d;
   phase_t        phase_q, phase_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic          hold_en_q, hold_en_d;
   logic          hold_er_q, hold_er_d;
   logic [1:0]    speed_q, speed_d;
   logic          fresh_q;
   logic [1:0]    sel_norm;
   logic [CW-1:0] last_q, last_d;
   int            div_d;

   logic          ready_q, ready_d;
   logic          txc1_q, txc1_d, txc2_q, txc2_d;
   logic [3:0]    td1_q, td1_d, td2_q, td2_d;
   logic          ctl1_q, ctl2_q;
   logic          change_q, change_d;

   always_comb begin
      sel_norm    = speed_selection[1] ? 2'b10 : speed_selection;
      last_q      = (speed_q == 2'b01) ? LAST_100 : LAST_10;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      hold_data_d = hold_data_q;
      hold_en_d   = hold_en_q;
      hold_er_d   = hold_er_q;
      speed_d     = speed_q;
      change_d    = 1'b0;

      // The first cycle after reset shows the cnt=0 slot position without advancing.
      if (!fresh_q && !speed_q[1]) begin
         if (cnt_q == last_q) begin
            cnt_d   = '0;
            phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (ready_q) begin
         hold_data_d = s_txd;
         hold_en_d   = s_tx_en;
         hold_er_d   = s_tx_er;
         // Speed only switches between frames, on an idle byte boundary.
         if (!s_tx_en && !s_tx_er && (sel_norm != speed_q)) begin
            speed_d     = sel_norm;
            change_d    = 1'b1;
            cnt_d       = '0;
            phase_d     = PH_LO;
            hold_data_d = 8'h00;
            hold_en_d   = 1'b0;
            hold_er_d   = 1'b0;
         end
      end

      last_d = (speed_d == 2'b01) ? LAST_100 : LAST_10;
      div_d  = (speed_d == 2'b01) ? DIV_100 : DIV_10;
      if (speed_d[1]) begin
         ready_d = 1'b1;
         txc1_d  = 1'b1;
         txc2_d  = 1'b0;
         td1_d   = hold_data_d[3:0];
         td2_d   = hold_data_d[7:4];
      end else begin
         ready_d = (cnt_d == last_d) && (phase_d == PH_HI);
         txc1_d  = (2 * int'(cnt_d)) < div_d;
         txc2_d  = (2 * int'(cnt_d) + 1) < div_d;
         td1_d   = (phase_d == PH_HI) ? hold_data_d[7:4] : hold_data_d[3:0];
         td2_d   = td1_d;
      end
   end

   always_ff @(posedge gmii_tx_clk) begin
      if (reset) begin
         cnt_q       <= '0;
         phase_q     <= PH_LO;
         hold_data_q <= 8'h00;
         hold_en_q   <= 1'b0;
         hold_er_q   <= 1'b0;
         speed_q     <= sel_norm;
         fresh_q     <= 1'b1;
         ready_q     <= 1'b0;
         txc1_q      <= 1'b0;
         txc2_q      <= 1'b0;
         td1_q       <= 4'h0;
         td2_q       <= 4'h0;
         ctl1_q      <= 1'b0;
         ctl2_q      <= 1'b0;
         change_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         hold_data_q <= hold_data_d;
         hold_en_q   <= hold_en_d;
         hold_er_q   <= hold_er_d;
         speed_q     <= speed_d;
         fresh_q     <= 1'b0;
         ready_q     <= ready_d;
         txc1_q      <= txc1_d;
         txc2_q      <= txc2_d;
         td1_q       <= td1_d;
         td2_q       <= td2_d;
         ctl1_q      <= hold_en_d;
         ctl2_q      <= hold_en_d ^ hold_er_d;
         change_q    <= change_d;
      end
   end

   assign s_tx_ready   = ready_q;
   assign txc_d1       = txc1_q;
   assign txc_d2       = txc2_q;
   assign td_d1        = td1_q;
   assign td_d2        = td2_q;
   assign ctl_d1       = ctl1_q;
   assign ctl_d2       = ctl2_q;
   assign speed_active = speed_q;
   assign speed_change = change_q;

endmodule

// File: doc/rgmii_tx_rate_adapter.md
RGMII_TX_RATE_ADAPTER -- requirements
Module: rgmii_tx_rate_adapter

Interface
REQ-001 SHALL have parameter DIV_100, default 5: gmii_tx_clk cycles per 25 MHz TXC period in 100M mode; legal range >= 2.
REQ-002 SHALL have parameter DIV_10, default 50: gmii_tx_clk cycles per 2.5 MHz TXC period in 10M mode; legal range >= 2.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports in this order:
- gmii_tx_clk  in  1  125 MHz clock, the only clock
- reset  in  1  synchronous active-high reset
- speed_selection  in  2  requested speed: 1x=1000M, 01=100M, 00=10M
- s_txd  in  8  GMII byte
- s_tx_en  in  1  GMII enable
- s_tx_er  in  1  GMII error
- s_tx_ready  out  1  byte slot consumed this cycle
- txc_d1, txc_d2  out  1 each  TXC ODDR rising/falling-edge data
- td_d1, td_d2  out  4 each  TD ODDR rising/falling-edge data
- ctl_d1, ctl_d2  out  1 each  TX_CTL ODDR rising/falling-edge data
- speed_active  out  2  currently applied speed
- speed_change  out  1  one-cycle pulse when a new speed is applied

Function
REQ-004 SHALL hold one byte register (hold_d, hold_en, hold_er), a cycle counter cnt, and a nibble phase bit.
REQ-005 cnt SHALL be wide enough for max(DIV_10, DIV_100)-1; DIV SHALL mean DIV_100 in 100M mode and DIV_10 in 10M mode.
REQ-006 In 1000M mode, s_tx_ready SHALL be 1 in every cycle outside reset, and the input byte SHALL be captured into the hold register on every cycle.
REQ-007 In 1000M mode, outputs SHALL be: txc_d1=1, txc_d2=0, td_d1=hold_d[3:0], td_d2=hold_d[7:4]; latency is 1 cycle from input to outputs.
REQ-008 In 10/100M mode, cnt SHALL count 0..DIV-1 and then wrap; phase SHALL toggle when cnt wraps.
REQ-009 In 10/100M mode, with c = cnt: txc_d1 = (2c < DIV) and txc_d2 = (2c+1 < DIV).
- DIV=5 per-cycle (d1,d2) sequence: (1,1),(1,1),(1,0),(0,0),(0,0).
REQ-010 In 10/100M mode, s_tx_ready SHALL be 1 only when cnt==DIV-1 and phase==1; the byte SHALL be captured on that edge.
- Ready period is therefore 2*DIV cycles.
REQ-011 In 10/100M mode, td_d1 = td_d2 SHALL be hold_d[3:0] while phase==0 and hold_d[7:4] while phase==1.
- The first nibble appears in the cycle after capture, with cnt=0, phase=0.
REQ-012 In all modes, ctl_d1 = hold_en and ctl_d2 = hold_en ^ hold_er, held constant for the whole byte slot.
REQ-013 speed_selection 2'b11 SHALL be treated identically to 2'b10.
REQ-014 A speed change SHALL be applied only at a byte-capture edge where the captured byte has s_tx_en=0 and s_tx_er=0.
REQ-015 While a frame is active, a speed change SHALL be deferred.
- Requests changed back before the deferral ends are never applied.
REQ-016 On applying a new speed, the block SHALL:
- update speed_active;
- pulse speed_change for 1 cycle;
- clear cnt and phase to 0;
- load the hold register with the idle byte (0, en=0, er=0).
REQ-017 The new speed's waveform SHALL begin in the next cycle.

Reset
REQ-018 While reset=1, at each clock edge the block SHALL:
- clear cnt, phase and the hold register;
- drive s_tx_ready, txc_d1, txc_d2, td_d1, td_d2, ctl_d1, ctl_d2 and speed_change to 0;
- load speed_active from speed_selection (1x normalised to 10).
REQ-019 Reset asserted mid-frame SHALL abort the frame with no residual nibble.
- After release, 10/100M mode restarts at cnt=0, phase=0.
- The first ready pulse comes 2*DIV cycles after release.

Verification
REQ-020 1000M test:
- Stimulus: bytes 0x55, 0xD5 with en=1.
- Response: cycle+1 gives td_d1=5, td_d2=5; cycle+2 gives td_d1=5, td_d2=D.
- Throughout: ctl 1/1, txc 1/0, s_tx_ready constantly 1.
REQ-021 100M test, DIV=5:
- txc sequence repeats (1,1),(1,1),(1,0),(0,0),(0,0).
- s_tx_ready pulses every 10 cycles.
- Byte 0xA5 with en=1: td=5 for 5 cycles, then td=A for 5 cycles, ctl 1/1.
REQ-022 10M test:
- s_tx_ready pulses every 100 cycles.
- txc_d1 is high for cycles 0..24 of each period and low for cycles 25..49.
REQ-023 Error/extend test:
- en=1, er=1 gives ctl 1/0.
- en=0, er=1 gives ctl 0/1.
- en=0, er=0 gives ctl 0/0.
REQ-024 Deferred speed change test:
- Stimulus: switch 1000M to 100M mid-frame with en=1 for 20 more bytes.
- Response: speed_active stays 10 until the first idle byte is captured; then speed_change pulses once and the 100M pattern starts at cnt=0.
REQ-025 Reset mid-frame test:
- Stimulus: 100M mode, assert reset for 1 cycle at cnt=3, phase=1.
- Response: all outputs 0 in the next cycle; after release, the ready pulse arrives exactly 10 cycles later.
